hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Sequential multiply/divide unit that owns the architectural HI/LO register pair. It computes MULT/MULTU/DIV/DIVU iteratively over 33 cycles and accepts direct writes (MTHI, MTLO, full 64-bit load). It presents the current HI/LO value to the combinational ALU's `hi_lo_in` input, and takes the ALU's 64-bit `hi_lo` result back for madd/maddu commit. It sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

## Interface
- `XLEN`, 32: operand width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  command valid. Sampled only when `busy`=0.
- `op`  in  3  command: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110 LOAD (write `hi_lo_wr`), 111 reserved.
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  32  rt operand: multiplier or divisor.
- `hi_lo_wr`  in  64  value for LOAD, normally the ALU's madd/maddu `hi_lo` output.
- `hi_lo_out`  out  64  {HI,LO}. Drives the ALU `hi_lo_in`.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse: command has committed.
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for a reserved or compiled-out op.

## Operation
- States are IDLE, CALC and FIX.
- IDLE, `start`=1:
  - MULT/MULTU/DIV/DIVU: latch the operands. For signed ops, convert to magnitudes and record the result signs. Load count=31 and go to CALC.
  - MTHI: HI←a. MTLO: LO←a. LOAD: {HI,LO}←hi_lo_wr. All three stay in IDLE and pulse `done` next cycle.
  - op=111: HI/LO unchanged; `done` and `illegal` pulse next cycle.
- CALC performs one radix-2 step per cycle and decrements count.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring step on a 64-bit remainder/quotient register.
  - Go to FIX when count=0.
- FIX applies sign correction:
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: quotient takes sign(a)^sign(b); remainder takes sign(a).
  - Write HI/LO, then return to IDLE.
- Result mapping:
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- Boundaries:
  - Divide by zero: LO=32'hFFFF_FFFF, HI=a. Not illegal.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
  - MULT of -2^31 × -2^31 = 64'h4000_0000_0000_0000. No overflow condition exists.
- `start` while `busy`=1: ignored entirely. No queueing, and no effect on the in-flight op.
- `hi_lo_out` shows the old value throughout CALC/FIX and updates only at commit. Intermediate values are never visible.
- Reset (any state, including mid-CALC) returns to IDLE and discards the operation, with no `done`.
- Reset values: HI=0, LO=0, `hi_lo_out`=0, `busy`=0, `done`=0, `illegal`=0.

## Timing
- Command accepted at edge E0.
- Iterative ops:
  - `busy`=1 from after E0 through E33.
  - CALC occupies E1..E32; FIX commits at E33.
  - `hi_lo_out` is new and `done`=1 in the cycle after E33; `busy` is 0 in that same cycle.
  - Total latency 33 cycles. Back-to-back start is allowed in the `done` cycle.
- Direct writes (MTHI/MTLO/LOAD): commit at E0; `hi_lo_out` is new and `done`=1 the following cycle. Back-to-back every cycle is allowed.
- Outputs are registered with no combinational path from inputs. The ALU madd loop (`hi_lo_out`→ALU→`hi_lo_wr`) is therefore broken by the HI/LO flops.

## Configuration
- `MDU_DIV_EN` defined: divide datapath present and DIV/DIVU execute as above.
- `MDU_DIV_EN` undefined:
  - The divider is removed.
  - DIV/DIVU behave as op=111: no busy, HI/LO unchanged, `done`+`illegal` one cycle after acceptance.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encoding as a typedef enum (MDU_MULTU … MDU_RSVD);
  - the state enum (S_IDLE, S_CALC, S_FIX);
  - localparams for the iteration count (32) and the div-by-zero quotient constant.
- Sub-module `mdu_div_step`: combinational single restoring-divide step (remainder, divisor → next remainder, quotient bit). Instantiated only under `MDU_DIV_EN`.
- Multiply step and FIX logic stay in `hilo_mdu`.

## Test plan
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → after 33 cycles, `done` with HI=32'hFFFF_FFFE, LO=32'h0000_0001. `busy` is high for exactly 33 cycles.
- MULT a=-7, b=3 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB. Then DIV a=-7, b=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU a=100, b=0 → LO=32'hFFFF_FFFF, HI=100, `illegal`=0. DIV 32'h8000_0000 / -1 → LO=32'h8000_0000, HI=0.
- MTHI 32'h1234_5678, then MTLO 32'h9ABC_DEF0 on the next cycle, then LOAD 64'h1 → `hi_lo_out` sequence is 64'h1234_5678_0000_0000 → 64'h1234_5678_9ABC_DEF0 → 64'h1. Each `done` is one cycle after its command.
- Start DIVU 50/7, assert `start` with MULTU at cycle 10, then drop `rst_n` at cycle 20 of a second DIVU → first op yields LO=7, HI=1 with the MULTU ignored. After reset: no `done`, `hi_lo_out`=0, `busy`=0.
- op=111 (and DIV when `MDU_DIV_EN` is undefined) with HI/LO=64'hA5 → `done`+`illegal` one cycle later, `hi_lo_out` stays 64'hA5.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int          MDU_XLEN   = 32;
  localparam int          MDU_ITER   = 32;
  localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MDU_MULTU = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_DIVU  = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_LOAD  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  // Two's-complement negate when neg is set; also used to restore result signs.
  function automatic logic [MDU_XLEN-1:0] mdu_mag(input logic [MDU_XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide step: shifted partial remainder minus divisor, keep if no borrow.
// Purely combinational; the caller guarantees i_rem < 2*i_div for a nonzero divisor.
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [MDU_XLEN:0]   i_rem,
  input  logic [MDU_XLEN-1:0] i_div,
  output logic [MDU_XLEN-1:0] o_rem,
  output logic                o_q
);

  logic [MDU_XLEN:0] w_diff;

  always_comb begin
    w_diff = i_rem - {1'b0, i_div};
    o_q    = ~w_diff[MDU_XLEN];
    o_rem  = o_q ? w_diff[MDU_XLEN-1:0] : i_rem[MDU_XLEN-1:0];
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO owner: 33-cycle MULT/DIV (busy stalls, start ignored while busy), 1-cycle MTHI/MTLO/LOAD.
// The divider exists only when MDU_DIV_EN is defined; otherwise DIV/DIVU report illegal.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  logic [2*XLEN-1:0] i_hi_lo_wr,
  output logic [2*XLEN-1:0] o_hi_lo_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_illegal
);

  mdu_state_e        r_state;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opd;
  logic              r_neg_q;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;
  logic              r_illegal;

  logic              w_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

`ifdef MDU_DIV_EN
  logic              r_is_div;
  logic              r_neg_r;
  logic              r_div0;
  logic [XLEN-1:0]   w_div_rem;
  logic              w_div_q;

  mdu_div_step u_div_step (
    .i_rem (r_acc[2*XLEN-1:XLEN-1]),
    .i_div (r_opd),
    .o_rem (w_div_rem),
    .o_q   (w_div_q)
  );
`endif

  always_comb begin
    w_signed  = (i_op == MDU_MULT) || (i_op == MDU_DIV);
    w_sa      = w_signed & i_a[XLEN-1];
    w_sb      = w_signed & i_b[XLEN-1];
    // Shift-add: upper half accumulates, multiplier drains out of the lower half.
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    w_step    = {w_mul_sum, r_acc[XLEN-1:1]};
    w_prod    = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_res_hi  = w_prod[2*XLEN-1:XLEN];
    w_res_lo  = w_prod[XLEN-1:0];
`ifdef MDU_DIV_EN
    if (r_is_div) begin
      w_step   = {w_div_rem, r_acc[XLEN-2:0], w_div_q};
      w_res_lo = r_div0 ? MDU_DIV0_Q : mdu_mag(r_acc[XLEN-1:0], r_neg_q);
      w_res_hi = mdu_mag(r_acc[2*XLEN-1:XLEN], r_neg_r);
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_neg_q   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            case (mdu_op_e'(i_op))
              MDU_MULTU, MDU_MULT: begin
                r_opd   <= mdu_mag(i_a, w_sa);
                r_acc   <= {{XLEN{1'b0}}, mdu_mag(i_b, w_sb)};
                r_neg_q <= w_sa ^ w_sb;
                r_cnt   <= 5'(MDU_ITER - 1);
                r_busy  <= 1'b1;
                r_state <= S_CALC;
`ifdef MDU_DIV_EN
                r_is_div <= 1'b0;
`endif
              end
`ifdef MDU_DIV_EN
              MDU_DIVU, MDU_DIV: begin
                r_opd    <= mdu_mag(i_b, w_sb);
                r_acc    <= {{XLEN{1'b0}}, mdu_mag(i_a, w_sa)};
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_div0   <= (i_b == '0);
                r_is_div <= 1'b1;
                r_cnt    <= 5'(MDU_ITER - 1);
                r_busy   <= 1'b1;
                r_state  <= S_CALC;
              end
`endif
              MDU_MTHI: begin
                r_hi   <= i_a;
                r_done <= 1'b1;
              end
              MDU_MTLO: begin
                r_lo   <= i_a;
                r_done <= 1'b1;
              end
              MDU_LOAD: begin
                {r_hi, r_lo} <= i_hi_lo_wr;
                r_done       <= 1'b1;
              end
              default: begin
                r_done    <= 1'b1;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          if (r_cnt == '0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_hi_lo_out = {r_hi, r_lo};
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed vector table, hand-built timing/reset sequences, and random commands
// checked against an arithmetic model; honours MDU_DIV_EN the same way as the design.
module tb_hilo_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [2:0] OP_MULTU = 3'd0, OP_MULT = 3'd1, OP_DIVU = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4, OP_MTLO = 3'd5, OP_LOAD = 3'd6, OP_RSVD = 3'd7;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [63:0] i_hi_lo_wr = '0;
  logic [63:0] o_hi_lo_out;
  logic        o_busy;
  logic        o_done;
  logic        o_illegal;

  hilo_mdu #(.XLEN(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_hi_lo_wr  (i_hi_lo_wr),
    .o_hi_lo_out (o_hi_lo_out),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] m_hilo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] wr;
    logic [63:0] hilo;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result straight from integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] wr, input logic [63:0] old,
                                output logic [63:0] hilo, output logic ill, output int lat);
    longint sa, sb, q, r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    hilo = old;
    ill  = 1'b0;
    lat  = 1;
    case (op)
      OP_MULTU: begin hilo = {32'd0, a} * {32'd0, b}; lat = 34; end
      OP_MULT:  begin hilo = sa * sb; lat = 34; end
      OP_DIVU, OP_DIV: begin
        if (!DIV_EN) ill = 1'b1;
        else begin
          lat = 34;
          if (b == 32'd0) hilo = {a, 32'hFFFF_FFFF};
          else if (op == OP_DIVU) hilo = {a % b, a / b};
          else begin
            q = sa / sb;
            r = sa % sb;
            hilo = {r[31:0], q[31:0]};
          end
        end
      end
      OP_MTHI: hilo = {a, old[31:0]};
      OP_MTLO: hilo = {old[63:32], a};
      OP_LOAD: hilo = wr;
      default: ill = 1'b1;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] wr, input logic [63:0] exp_hilo,
                         input logic exp_ill, input int exp_lat, input bit noise);
    int k, busy_n;
    bit stable;
    i_start = 1'b1; i_op = op; i_a = a; i_b = b; i_hi_lo_wr = wr;
    @(negedge i_clk);
    i_start = 1'b0;
    k = 1; busy_n = 0; stable = 1'b1;
    while (!o_done && k < 60) begin
      if (o_busy) busy_n++;
      if (o_hi_lo_out !== m_hilo) stable = 1'b0;
      if (noise) begin
        i_start = 1'($urandom % 2); i_op = 3'($urandom % 8); i_a = $urandom; i_b = $urandom;
      end
      @(negedge i_clk);
      k++;
    end
    i_start = 1'b0;
    check({name, ".latency"}, 64'(k), 64'(exp_lat));
    check({name, ".hilo"}, o_hi_lo_out, exp_hilo);
    check({name, ".illegal"}, 64'(o_illegal), 64'(exp_ill));
    check({name, ".busy_at_done"}, 64'(o_busy), 64'd0);
    check({name, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({name, ".hilo_held"}, 64'(stable), 64'd1);
    m_hilo = exp_hilo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] prev, e_hilo, first_exp;
    logic        e_ill;
    int          e_lat, k, dones;
    logic [2:0]  op, first_op;
    logic [31:0] a, b;
    logic [63:0] wr;

    // Reset dominates a pending command.
    i_start = 1'b1; i_op = OP_LOAD; i_hi_lo_wr = 64'hDEAD_BEEF_0000_0001;
    repeat (3) @(negedge i_clk);
    check("reset.hilo", o_hi_lo_out, 64'd0);
    check("reset.busy", 64'(o_busy), 64'd0);
    check("reset.done", 64'(o_done), 64'd0);
    check("reset.illegal", 64'(o_illegal), 64'd0);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);

    prev = 64'hFFFF_FFFF_FFFF_FFEB;
    tbl.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 34});
    tbl.push_back('{OP_MULT, 32'hFFFF_FFF9, 32'd3, 64'd0, prev, 1'b0, 34});
    tbl.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0,
                    DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : prev, !DIV_EN, DIV_EN ? 34 : 1});
    if (DIV_EN) prev = 64'hFFFF_FFFF_FFFF_FFFD;
    tbl.push_back('{OP_DIVU, 32'd100, 32'd0, 64'd0,
                    DIV_EN ? 64'h0000_0064_FFFF_FFFF : prev, !DIV_EN, DIV_EN ? 34 : 1});
    if (DIV_EN) prev = 64'h0000_0064_FFFF_FFFF;
    tbl.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
                    DIV_EN ? 64'h0000_0000_8000_0000 : prev, !DIV_EN, DIV_EN ? 34 : 1});
    tbl.push_back('{OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b0, 34});
    tbl.push_back('{OP_LOAD, 32'd0, 32'd0, 64'hA5, 64'hA5, 1'b0, 1});
    tbl.push_back('{OP_RSVD, 32'h1111_1111, 32'h2222_2222, 64'd7, 64'hA5, 1'b1, 1});
    tbl.push_back('{OP_DIV, 32'd20, 32'd6, 64'd0,
                    DIV_EN ? 64'h0000_0002_0000_0003 : 64'hA5, !DIV_EN, DIV_EN ? 34 : 1});
    foreach (tbl[i])
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wr,
              tbl[i].hilo, tbl[i].ill, tbl[i].lat, 1'b0);

    // Direct writes on consecutive edges.
    run_cmd("clear", OP_LOAD, 32'd0, 32'd0, 64'd0, 64'd0, 1'b0, 1, 1'b0);
    i_start = 1'b1; i_op = OP_MTHI; i_a = 32'h1234_5678;
    @(negedge i_clk);
    check("b2b.mthi", o_hi_lo_out, 64'h1234_5678_0000_0000);
    check("b2b.mthi_done", 64'(o_done), 64'd1);
    i_op = OP_MTLO; i_a = 32'h9ABC_DEF0;
    @(negedge i_clk);
    check("b2b.mtlo", o_hi_lo_out, 64'h1234_5678_9ABC_DEF0);
    check("b2b.mtlo_done", 64'(o_done), 64'd1);
    i_op = OP_LOAD; i_hi_lo_wr = 64'd1;
    @(negedge i_clk);
    check("b2b.load", o_hi_lo_out, 64'd1);
    check("b2b.load_done", 64'(o_done), 64'd1);
    i_start = 1'b0;
    @(negedge i_clk);
    check("b2b.idle_done", 64'(o_done), 64'd0);
    m_hilo = 64'd1;

    // Start during busy is ignored; reset mid-operation discards it.
    first_op  = DIV_EN ? OP_DIVU : OP_MULTU;
    first_exp = DIV_EN ? 64'h0000_0001_0000_0007 : 64'h0000_0000_0000_015E;
    i_start = 1'b1; i_op = first_op; i_a = 32'd50; i_b = 32'd7;
    @(negedge i_clk);
    k = 1;
    while (!o_done && k < 60) begin
      if (k == 10) begin
        i_start = 1'b1; i_op = OP_MULTU; i_a = 32'hFFFF_FFFF; i_b = 32'd3;
      end else i_start = 1'b0;
      @(negedge i_clk);
      k++;
    end
    i_start = 1'b0;
    check("ign.latency", 64'(k), 64'd34);
    check("ign.hilo", o_hi_lo_out, first_exp);
    i_start = 1'b1; i_op = first_op; i_a = 32'd1000; i_b = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (19) @(negedge i_clk);
    check("rst.busy_before", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("rst.busy", 64'(o_busy), 64'd0);
    check("rst.hilo", o_hi_lo_out, 64'd0);
    i_rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) dones++;
      @(negedge i_clk);
    end
    check("rst.no_done", 64'(dones), 64'd0);
    check("rst.hilo_after", o_hi_lo_out, 64'd0);
    m_hilo = 64'd0;

    // Random commands, issued back-to-back in the done cycle, with noise while busy.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom % 8);
      a  = pick();
      b  = pick();
      wr = {$urandom, $urandom};
      model(op, a, b, wr, m_hilo, e_hilo, e_ill, e_lat);
      run_cmd($sformatf("rnd%0d_op%0d", n, op), op, a, b, wr, e_hilo, e_ill, e_lat, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
